// File: rtl/card_game_pkg.sv
// Shared types and constants for the memory-card game turn logic.
package card_game_pkg;

  localparam int ADDR_W        = 6;
  localparam int VAL_W         = 5;
  localparam int NUM_CARDS_DEF = 36;

  localparam logic [ADDR_W-1:0] NO_CARD = 6'h3F;

  typedef enum logic [2:0] {
    WAIT_FIRST,
    READ1,
    WAIT_SECOND,
    READ2,
    COMPARE,
    SHOW_MISMATCH,
    DONE
  } turn_state_t;

endpackage

// File: rtl/card_turn_controller_if.sv
// Pick strobe from the cursor/button logic plus the card-memory read port.
// The master side is the board environment (picker and memory), the slave
// side is the turn controller.
interface card_turn_controller_if;
  import card_game_pkg::*;

  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [VAL_W-1:0]  mem_rdata;

  modport master (output sel_valid, output sel_addr, output mem_rdata, input mem_raddr);
  modport slave  (input sel_valid, input sel_addr, input mem_rdata, output mem_raddr);

endinterface

// File: rtl/card_hold_timer.sv
// Down-counter for the mismatch display time. load primes the count so that
// expired rises on the HOLD-th enabled cycle after the load.
module card_hold_timer #(
  parameter int HOLD = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [W-1:0] count;

  // count down while enabled, stopping at the terminal value
  always_ff @(posedge clock) begin
    if (reset)                  count <= '0;
    else if (load)              count <= W'(HOLD - 1);
    else if (en && count != '0) count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/card_turn_controller.sv
// Turn sequencer for the 6x6 memory card game.
// Optional feature: define CARD_CTRL_MOVE_CNT_EN to build the saturating
// move counter; otherwise move_count is tied to zero.
//
// state         | meaning
// WAIT_FIRST    | idle, waiting for the first pick of a turn
// READ1         | reading the first card's value
// WAIT_SECOND   | waiting for the second pick
// READ2         | reading the second card's value
// COMPARE       | one cycle, compare the two values
// SHOW_MISMATCH | unequal pair held face-up
// DONE          | all pairs found, picks ignored until reset
module card_turn_controller
  import card_game_pkg::*;
#(
  parameter int NUM_CARDS     = NUM_CARDS_DEF,
  parameter int READ_LAT      = 1,
  parameter int MISMATCH_HOLD = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  card_turn_controller_if.slave bus,
  output logic [NUM_CARDS-1:0] face_up_mask,
  output logic [NUM_CARDS-1:0] matched_mask,
  output logic [ADDR_W-1:0]    card1_loc,
  output logic [ADDR_W-1:0]    card2_loc,
  output logic [4:0]           pairs_found,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 busy,
  output logic                 game_over,
  output logic [9:0]           move_count
);

  localparam logic [NUM_CARDS-1:0] ONE = {{(NUM_CARDS-1){1'b0}}, 1'b1};

  turn_state_t       state, state_next;
  logic [1:0]        rd_cnt;
  logic              rd_done;
  logic [VAL_W-1:0]  val1, val2;
  logic [ADDR_W-1:0] raddr;
  logic [63:0]       matched_ext;
  logic              pick_ok;
  logic              hold_load;
  logic              hold_expired;

  assign matched_ext   = 64'(matched_mask);
  assign rd_done       = (rd_cnt == 2'(READ_LAT));
  assign bus.mem_raddr = raddr;

  card_hold_timer #(.HOLD(MISMATCH_HOLD)) u_hold (
    .clock   (clock),
    .reset   (reset),
    .load    (hold_load),
    .en      (state == SHOW_MISMATCH),
    .expired (hold_expired)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= WAIT_FIRST;
    else       state <= state_next;
  end

  // next-state, pick qualification and status outputs
  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    pick_ok    = bus.sel_valid && (int'(bus.sel_addr) < NUM_CARDS)
                 && !matched_ext[bus.sel_addr];
    busy       = !(state == WAIT_FIRST || state == WAIT_SECOND);
    game_over  = (state == DONE);
    case (state)
      WAIT_FIRST:    if (pick_ok) state_next = READ1;
      READ1:         if (rd_done) state_next = WAIT_SECOND;
      WAIT_SECOND:   if (pick_ok && bus.sel_addr != card1_loc) state_next = READ2;
      READ2:         if (rd_done) state_next = COMPARE;
      COMPARE: begin
        if (val1 == val2) begin
          state_next = (pairs_found == 5'(NUM_CARDS/2 - 1)) ? DONE : WAIT_FIRST;
        end else begin
          state_next = SHOW_MISMATCH;
          hold_load  = 1'b1;
        end
      end
      SHOW_MISMATCH: if (hold_expired) state_next = WAIT_FIRST;
      DONE:          state_next = DONE;
      default:       state_next = WAIT_FIRST;
    endcase
  end

  // turn datapath: pick locations, read values, masks, pair count, pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      face_up_mask   <= '0;
      matched_mask   <= '0;
      card1_loc      <= NO_CARD;
      card2_loc      <= NO_CARD;
      pairs_found    <= '0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      raddr          <= '0;
      rd_cnt         <= '0;
      val1           <= '0;
      val2           <= '0;
    end else begin
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      rd_cnt         <= (state == READ1 || state == READ2) ? rd_cnt + 2'd1 : 2'd0;
      case (state)
        WAIT_FIRST: if (state_next == READ1) begin
          card1_loc    <= bus.sel_addr;
          raddr        <= bus.sel_addr;
          face_up_mask <= face_up_mask | (ONE << bus.sel_addr);
        end
        READ1: if (rd_done) val1 <= bus.mem_rdata;
        WAIT_SECOND: if (state_next == READ2) begin
          card2_loc    <= bus.sel_addr;
          raddr        <= bus.sel_addr;
          face_up_mask <= face_up_mask | (ONE << bus.sel_addr);
        end
        READ2: if (rd_done) val2 <= bus.mem_rdata;
        COMPARE: begin
          if (val1 == val2) begin
            matched_mask <= matched_mask | (ONE << card1_loc) | (ONE << card2_loc);
            pairs_found  <= pairs_found + 5'd1;
            match_pulse  <= 1'b1;
            card1_loc    <= NO_CARD;
            card2_loc    <= NO_CARD;
          end else begin
            mismatch_pulse <= 1'b1;
          end
        end
        SHOW_MISMATCH: if (hold_expired) begin
          face_up_mask <= face_up_mask & ~(ONE << card1_loc) & ~(ONE << card2_loc);
          card1_loc    <= NO_CARD;
          card2_loc    <= NO_CARD;
        end
        default: ;
      endcase
    end
  end

`ifdef CARD_CTRL_MOVE_CNT_EN
  // completed-turn counter, saturating at its maximum
  always_ff @(posedge clock) begin
    if (reset)                                         move_count <= '0;
    else if (state == COMPARE && move_count != 10'h3FF) move_count <= move_count + 10'd1;
  end
`else
  assign move_count = '0;
`endif

endmodule

// File: tb/tb_card_turn_controller.sv
// Bench for card_turn_controller. Directed turns with hand-chosen card values;
// expected match/mismatch events go into a queue and a monitor checks them
// whenever the DUT pulses. Honours CARD_CTRL_MOVE_CNT_EN for move_count.
module tb_card_turn_controller;

  localparam int HOLD = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic [35:0] face_up_mask, matched_mask;
  logic [5:0]  card1_loc, card2_loc;
  logic [4:0]  pairs_found;
  logic        match_pulse, mismatch_pulse, busy, game_over;
  logic [9:0]  move_count;

  card_turn_controller_if bus();

  card_turn_controller #(.NUM_CARDS(36), .READ_LAT(1), .MISMATCH_HOLD(HOLD)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .face_up_mask   (face_up_mask),
    .matched_mask   (matched_mask),
    .card1_loc      (card1_loc),
    .card2_loc      (card2_loc),
    .pairs_found    (pairs_found),
    .match_pulse    (match_pulse),
    .mismatch_pulse (mismatch_pulse),
    .busy           (busy),
    .game_over      (game_over),
    .move_count     (move_count)
  );

  always #5 clock = ~clock;

  // card memory model, one cycle read latency
  logic [4:0] card_val [64];
  always @(posedge clock) bus.mem_rdata <= card_val[bus.mem_raddr];

  typedef struct {
    logic       is_match;
    logic [5:0] a;
    logic [5:0] b;
    logic [4:0] pairs;
  } exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [35:0] model_matched;
  int          model_pairs;
  int          model_turns;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [9:0] exp_moves(input int turns);
`ifdef CARD_CTRL_MOVE_CNT_EN
    return 10'(turns);
`else
    return 10'(0 * turns);
`endif
  endfunction

  // monitor: compare every pulse against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (match_pulse || mismatch_pulse)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {match_pulse, mismatch_pulse}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {match_pulse, mismatch_pulse}, {e.is_match, !e.is_match});
          chk("pulse_pairs", pairs_found, e.pairs);
          if (e.is_match) begin
            chk("match_bits", {matched_mask[e.a], matched_mask[e.b]}, 2'b11);
            chk("match_locs", {card1_loc, card2_loc}, 12'hFFF);
          end else begin
            chk("mismatch_locs", {card1_loc, card2_loc}, {e.a, e.b});
            chk("mismatch_faceup", {face_up_mask[e.a], face_up_mask[e.b]}, 2'b11);
          end
        end
      end
    end
  end

  task automatic pick(input int a);
    bus.sel_valid = 1'b1;
    bus.sel_addr  = 6'(a);
    @(negedge clock);
    bus.sel_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && !game_over && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", n < 500, 1);
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!(match_pulse || mismatch_pulse) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("pulse_seen", n < 100, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_matched = '0;
    model_pairs   = 0;
    model_turns   = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_masks"}, {face_up_mask, matched_mask}, 0);
    chk({tag, "_locs"}, {card1_loc, card2_loc}, 12'hFFF);
    chk({tag, "_flags"}, {pairs_found, match_pulse, mismatch_pulse, busy, game_over}, 0);
    chk({tag, "_raddr"}, bus.mem_raddr, 0);
    chk({tag, "_moves"}, move_count, 0);
  endtask

  // full turn: load values, pick both cards, wait for the outcome to settle
  task automatic do_turn(input int a, input int b, input logic [4:0] va, input logic [4:0] vb);
    exp_t e;
    card_val[a] = va;
    card_val[b] = vb;
    if (va == vb) begin
      model_matched[a] = 1'b1;
      model_matched[b] = 1'b1;
      model_pairs++;
    end
    model_turns++;
    e.is_match = (va == vb);
    e.a = 6'(a);
    e.b = 6'(b);
    e.pairs = 5'(model_pairs);
    exp_q.push_back(e);
    wait_idle();
    pick(a);
    wait_idle();
    pick(b);
    wait_idle();
    chk("turn_locs", {card1_loc, card2_loc}, 12'hFFF);
    chk("turn_matched", matched_mask, model_matched);
    chk("turn_faceup", face_up_mask, model_matched);
  endtask

  initial begin
    int hold_cnt;
    bit busy_dropped;
    int remaining[$];
    exp_t e;

    for (int i = 0; i < 64; i++) card_val[i] = 5'd31;
    bus.sel_valid = 1'b0;
    bus.sel_addr  = '0;
    model_matched = '0;
    model_pairs   = 0;
    model_turns   = 0;

    // reset with a simultaneous pick: reset wins
    reset = 1'b1;
    bus.sel_valid = 1'b1;
    bus.sel_addr  = 6'd5;
    repeat (3) @(negedge clock);
    check_reset("reset_init");
    bus.sel_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    // matching pair 3/10
    do_turn(3, 10, 5'd7, 5'd7);
    chk("t1_pairs", pairs_found, 1);

    // mismatching pair 0/1 held exactly HOLD cycles
    card_val[0] = 5'd2;
    card_val[1] = 5'd5;
    model_turns++;
    e.is_match = 1'b0; e.a = 6'd0; e.b = 6'd1; e.pairs = 5'd1;
    exp_q.push_back(e);
    pick(0);
    wait_idle();
    pick(1);
    wait_pulse();
    hold_cnt = 0;
    busy_dropped = 1'b0;
    while (face_up_mask[0] && hold_cnt < 200) begin
      if (!busy) busy_dropped = 1'b1;
      hold_cnt++;
      @(negedge clock);
    end
    chk("t2_hold_cycles", hold_cnt, HOLD);
    chk("t2_busy_held", busy_dropped, 0);
    chk("t2_after", {busy, face_up_mask[1], card1_loc, card2_loc}, {2'b00, 12'hFFF});

    // ignored picks in WAIT_FIRST: matched card, out-of-range address
    pick(10);
    chk("t3_matched_first", {busy, card1_loc}, {1'b0, 6'h3F});
    pick(40);
    chk("t3_range_first", {busy, card1_loc, face_up_mask}, {1'b0, 6'h3F, model_matched});

    // ignored picks during READ1, WAIT_SECOND and SHOW_MISMATCH
    card_val[4] = 5'd1;
    card_val[5] = 5'd9;
    model_turns++;
    e.is_match = 1'b0; e.a = 6'd4; e.b = 6'd5; e.pairs = 5'd1;
    exp_q.push_back(e);
    pick(4);
    pick(6);
    chk("t3_during_read1", {card2_loc, face_up_mask[6]}, {6'h3F, 1'b0});
    wait_idle();
    pick(4);
    chk("t3_repeat_card1", {busy, card1_loc, card2_loc}, {1'b0, 6'd4, 6'h3F});
    pick(3);
    chk("t3_matched_second", {busy, card2_loc}, {1'b0, 6'h3F});
    pick(40);
    chk("t3_range_second", {busy, card2_loc}, {1'b0, 6'h3F});
    pick(5);
    wait_pulse();
    @(negedge clock);
    pick(7);
    chk("t3_during_show", {card1_loc, card2_loc, face_up_mask[7]}, {6'd4, 6'd5, 1'b0});
    wait_idle();
    chk("t3_after", {face_up_mask, card1_loc, card2_loc}, {model_matched, 12'hFFF});

    chk("moves_3", move_count, exp_moves(model_turns));

    // clear the rest of the board: 17 more matching pairs
    for (int i = 0; i < 36; i++) if (!model_matched[i]) remaining.push_back(i);
    for (int k = 0; k + 1 < remaining.size(); k += 2) begin
      chk("not_over_yet", game_over, 0);
      do_turn(remaining[k], remaining[k+1], 5'(k/2), 5'(k/2));
    end
    chk("t4_over", {game_over, busy, pairs_found}, {2'b11, 5'd18});
    chk("t4_all_matched", matched_mask, {36{1'b1}});
    pick(0);
    pick(12);
    repeat (3) @(negedge clock);
    chk("t4_pick_after_done", {game_over, card1_loc, pairs_found}, {1'b1, 6'h3F, 5'd18});
    chk("moves_20", move_count, exp_moves(model_turns));

    // reset while in READ2
    do_reset();
    check_reset("reset_done");
    card_val[0] = 5'd1;
    card_val[1] = 5'd2;
    pick(0);
    wait_idle();
    pick(1);
    chk("t5_in_read2", {busy, card2_loc}, {1'b1, 6'd1});
    do_reset();
    check_reset("reset_read2");
    repeat (5) @(negedge clock);
    chk("t5_read2_quiet", {busy, face_up_mask}, 0);

    // reset while in SHOW_MISMATCH
    card_val[2] = 5'd4;
    card_val[3] = 5'd6;
    e.is_match = 1'b0; e.a = 6'd2; e.b = 6'd3; e.pairs = 5'd0;
    exp_q.push_back(e);
    pick(2);
    wait_idle();
    pick(3);
    wait_pulse();
    repeat (3) @(negedge clock);
    do_reset();
    check_reset("reset_show");
    repeat (HOLD + 5) @(negedge clock);
    chk("t5_show_quiet", {busy, face_up_mask, card1_loc}, {1'b0, 36'd0, 6'h3F});

    // controller usable again after reset
    do_turn(2, 3, 5'd6, 5'd6);
    chk("t5_resume", {pairs_found, move_count}, {5'd1, exp_moves(1)});

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
